// File: rtl/i2s_cfg_seq_pkg.sv
`default_nettype none
// i2s_cfg_seq_pkg -- configuration bundles, mode and state encodings for the config sequencer.
// Revision 1.0
package i2s_cfg_seq_pkg;

  typedef struct packed {
    logic        lsb_first;
    logic        two_ch;
    logic [4:0]  bits_word;
    logic [3:0]  words;
    logic [1:0]  pdm_mode;
    logic [9:0]  pdm_decimation;
    logic [2:0]  pdm_shift;
    logic [1:0]  dsp_mode;
    logic [8:0]  dsp_offset;
    logic [15:0] dsp_setup_time;
    logic        rx_continuous;
  } slv_cfg_t;

  typedef struct packed {
    logic        lsb_first;
    logic        two_ch;
    logic [4:0]  bits_word;
    logic [3:0]  words;
    logic [1:0]  dsp_mode;
    logic [8:0]  dsp_offset;
    logic [15:0] dsp_setup_time;
  } mst_cfg_t;

  localparam int SLV_CFG_W = $bits(slv_cfg_t);
  localparam int MST_CFG_W = $bits(mst_cfg_t);

  typedef enum logic [1:0] {
    I2S = 2'd0,
    PDM = 2'd1,
    DSP = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STOP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LOAD  = 3'd4,
    ST_START = 3'd5
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/i2s_cfg_seq_fsm.sv
`default_nettype none
// i2s_cfg_seq_fsm -- stop / drain / load / start sequencer for one datapath channel.
// Revision 1.0
module i2s_cfg_seq_fsm
  import i2s_cfg_seq_pkg::*;
#(
  parameter int CFG_W         = 8,
  parameter int QUIET_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_en,
  input  logic [CFG_W-1:0] req_cfg,
  input  logic             activity,
  output logic             en,
  output logic [CFG_W-1:0] cfg,
  output logic             busy,
  output logic             timeout
);

  localparam int QW = $clog2(QUIET_CYCLES) + 1;
  localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT);

  seq_state_e       state;
  logic             pend_en;
  logic [CFG_W-1:0] pend_cfg;
  logic [QW-1:0]    quiet_cnt;
  logic [TW-1:0]    drain_cnt;
  logic [QW-1:0]    quiet_nxt;
  logic [TW-1:0]    drain_nxt;

  assign quiet_nxt = quiet_cnt + QW'(1);
  assign drain_nxt = drain_cnt + TW'(1);
  assign busy      = (state != ST_IDLE) && (state != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      cfg       <= '0;
      pend_en   <= 1'b0;
      pend_cfg  <= '0;
      quiet_cnt <= '0;
      drain_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            pend_en  <= req_en;
            pend_cfg <= req_cfg;
            state    <= ST_LOAD;
          end
        end
        ST_RUN: begin
          // Enables fall on the same edge that enters STOP.
          if (req) begin
            pend_en  <= req_en;
            pend_cfg <= req_cfg;
            en       <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          en        <= 1'b0;
          quiet_cnt <= '0;
          drain_cnt <= '0;
          state     <= ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_nxt;
          quiet_cnt <= activity ? '0 : quiet_nxt;
          // A quiet threshold reached on the timeout cycle is a clean load, not an error.
          if (!activity && (quiet_nxt == QUIET_LAST)) begin
            state <= ST_LOAD;
          end else if (drain_nxt == DRAIN_LAST) begin
            state   <= ST_LOAD;
            timeout <= 1'b1;
          end
        end
        ST_LOAD: begin
          cfg   <= pend_cfg;
          state <= pend_en ? ST_START : ST_IDLE;
        end
        ST_START: begin
          en    <= pend_en;
          state <= ST_RUN;
        end
        default: begin
          en    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_cfg_sequencer.sv
`default_nettype none
// i2s_cfg_sequencer -- applies register-side configuration to the RX (slave) and TX (master) paths safely.
// Revision 1.0
module i2s_cfg_sequencer
  import i2s_cfg_seq_pkg::*;
#(
  parameter int QUIET_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 slv_req_i,
  input  logic                 slv_req_en_i,
  input  logic [1:0]           slv_req_mode_i,
  input  logic [SLV_CFG_W-1:0] slv_req_cfg_i,
  input  logic                 rx_valid_i,
  output logic                 cfg_slave_en_o,
  output logic                 cfg_slave_pdm_en_o,
  output logic                 cfg_slave_dsp_en_o,
  output logic [SLV_CFG_W-1:0] cfg_slave_o,
  output logic                 slv_busy_o,
  output logic                 slv_err_o,
  input  logic                 mst_req_i,
  input  logic                 mst_req_en_i,
  input  logic                 mst_req_dsp_i,
  input  logic [MST_CFG_W-1:0] mst_req_cfg_i,
  input  logic                 tx_valid_i,
  input  logic                 tx_ready_i,
  output logic                 cfg_master_en_o,
  output logic                 cfg_master_dsp_en_o,
  output logic [MST_CFG_W-1:0] cfg_master_o,
  output logic                 mst_busy_o,
  output logic                 mst_err_o
);

  logic                 slv_req_ok;
  logic                 slv_req_bad;
  logic                 slv_en;
  logic                 slv_timeout;
  logic [SLV_CFG_W+1:0] slv_ext;
  logic [1:0]           slv_mode;

  logic                 mst_req_ok;
  logic                 mst_en;
  logic                 mst_timeout;
  logic [MST_CFG_W:0]   mst_ext;

  // The mode travels with the bundle so it changes only on load.
  assign slv_req_ok  = slv_req_i & ~slv_busy_o & (slv_req_mode_i != MODE_RSVD);
  assign slv_req_bad = slv_req_i & ~slv_busy_o & (slv_req_mode_i == MODE_RSVD);

  i2s_cfg_seq_fsm #(
    .CFG_W         (SLV_CFG_W + 2),
    .QUIET_CYCLES  (QUIET_CYCLES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_slv_fsm (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .req      (slv_req_ok),
    .req_en   (slv_req_en_i),
    .req_cfg  ({slv_req_mode_i, slv_req_cfg_i}),
    .activity (rx_valid_i),
    .en       (slv_en),
    .cfg      (slv_ext),
    .busy     (slv_busy_o),
    .timeout  (slv_timeout)
  );

  assign slv_mode           = slv_ext[SLV_CFG_W+1:SLV_CFG_W];
  assign cfg_slave_o        = slv_ext[SLV_CFG_W-1:0];
  assign cfg_slave_en_o     = slv_en;
  assign cfg_slave_pdm_en_o = slv_en & (slv_mode == PDM);
  assign cfg_slave_dsp_en_o = slv_en & (slv_mode == DSP);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slv_err_o <= 1'b0;
    end else if (slv_req_bad || slv_timeout) begin
      slv_err_o <= 1'b1;
    end else if (slv_req_ok) begin
      slv_err_o <= 1'b0;
    end
  end

  assign mst_req_ok = mst_req_i & ~mst_busy_o;

  i2s_cfg_seq_fsm #(
    .CFG_W         (MST_CFG_W + 1),
    .QUIET_CYCLES  (QUIET_CYCLES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_mst_fsm (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .req      (mst_req_ok),
    .req_en   (mst_req_en_i),
    .req_cfg  ({mst_req_dsp_i, mst_req_cfg_i}),
    .activity (tx_valid_i & tx_ready_i),
    .en       (mst_en),
    .cfg      (mst_ext),
    .busy     (mst_busy_o),
    .timeout  (mst_timeout)
  );

  assign cfg_master_o        = mst_ext[MST_CFG_W-1:0];
  assign cfg_master_en_o     = mst_en;
  assign cfg_master_dsp_en_o = mst_en & mst_ext[MST_CFG_W];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mst_err_o <= 1'b0;
    end else if (mst_timeout) begin
      mst_err_o <= 1'b1;
    end else if (mst_req_ok) begin
      mst_err_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_cfg_sequencer.sv
`default_nettype none
// tb_i2s_cfg_sequencer -- randomized requests checked every cycle against a per-path output timeline.
module tb_i2s_cfg_sequencer;
  import i2s_cfg_seq_pkg::*;

  localparam int Q     = 16;
  localparam int TO    = 1024;
  localparam int R_END = 5000;
  localparam int N     = R_END + 1250;
  localparam int NC    = N + 1100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn;
  logic                 slv_req_i, slv_req_en_i, rx_valid_i;
  logic [1:0]           slv_req_mode_i;
  logic [SLV_CFG_W-1:0] slv_req_cfg_i;
  logic                 cfg_slave_en_o, cfg_slave_pdm_en_o, cfg_slave_dsp_en_o;
  logic [SLV_CFG_W-1:0] cfg_slave_o;
  logic                 slv_busy_o, slv_err_o;
  logic                 mst_req_i, mst_req_en_i, mst_req_dsp_i, tx_valid_i, tx_ready_i;
  logic [MST_CFG_W-1:0] mst_req_cfg_i;
  logic                 cfg_master_en_o, cfg_master_dsp_en_o;
  logic [MST_CFG_W-1:0] cfg_master_o;
  logic                 mst_busy_o, mst_err_o;

  i2s_cfg_sequencer #(.QUIET_CYCLES(Q), .DRAIN_TIMEOUT(TO)) dut (
    .clk_i               (clk),
    .rstn_i              (rstn),
    .slv_req_i           (slv_req_i),
    .slv_req_en_i        (slv_req_en_i),
    .slv_req_mode_i      (slv_req_mode_i),
    .slv_req_cfg_i       (slv_req_cfg_i),
    .rx_valid_i          (rx_valid_i),
    .cfg_slave_en_o      (cfg_slave_en_o),
    .cfg_slave_pdm_en_o  (cfg_slave_pdm_en_o),
    .cfg_slave_dsp_en_o  (cfg_slave_dsp_en_o),
    .cfg_slave_o         (cfg_slave_o),
    .slv_busy_o          (slv_busy_o),
    .slv_err_o           (slv_err_o),
    .mst_req_i           (mst_req_i),
    .mst_req_en_i        (mst_req_en_i),
    .mst_req_dsp_i       (mst_req_dsp_i),
    .mst_req_cfg_i       (mst_req_cfg_i),
    .tx_valid_i          (tx_valid_i),
    .tx_ready_i          (tx_ready_i),
    .cfg_master_en_o     (cfg_master_en_o),
    .cfg_master_dsp_en_o (cfg_master_dsp_en_o),
    .cfg_master_o        (cfg_master_o),
    .mst_busy_o          (mst_busy_o),
    .mst_err_o           (mst_err_o)
  );

  // Expected outputs per path (0 = slave, 1 = master) per cycle, plus the planned activity.
  logic        e_en   [2][NC];
  logic [1:0]  e_sel  [2][NC];
  logic [63:0] e_cfg  [2][NC];
  logic        e_busy [2][NC];
  logic        e_err  [2][NC];
  logic        act    [2][NC];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pat_idx [2] = '{0, 0};
  int pat_tab_s [5] = '{1, 4, 2, 3, 5};
  int pat_tab_m [4] = '{1, 3, 2, 5};
  int rnd_pats  [5] = '{0, 0, 1, 4, 5};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Drain-window activity shapes, indexed from the first drain cycle.
  task automatic plan_drain(input int p, input int d, input int pat);
    for (int k = 0; k < TO; k++) begin
      case (pat)
        1: act[p][d+k] = 1'b0;
        2: act[p][d+k] = 1'b1;
        3: act[p][d+k] = (k < TO - Q);
        4: act[p][d+k] = (k == 10);
        5: act[p][d+k] = (k == Q - 1);
        default: ;
      endcase
    end
  endtask

  task automatic schedule(input int p, input int t, input logic nen, input logic [1:0] nsel,
                          input logic [63:0] ncfg, input int fpat);
    int  l;
    int  d;
    int  run;
    int  pat;
    bit  to;
    to = 1'b0;
    l  = t + 1;
    if (e_en[p][t]) begin
      d = t + 2;
      if (fpat >= 0) pat = fpat;
      else if (p == 0 && pat_idx[0] < 5) begin pat = pat_tab_s[pat_idx[0]]; pat_idx[0]++; end
      else if (p == 1 && pat_idx[1] < 4) begin pat = pat_tab_m[pat_idx[1]]; pat_idx[1]++; end
      else pat = rnd_pats[$urandom_range(0, 4)];
      plan_drain(p, d, pat);
      run = 0;
      for (int k = 0; k < TO; k++) begin
        run = act[p][d+k] ? 0 : run + 1;
        if (run == Q) begin l = d + k + 1; break; end
        if (k + 1 == TO) begin l = d + k + 1; to = 1'b1; break; end
      end
    end
    for (int c = t + 1; c < NC; c++) begin
      e_busy[p][c] = (c <= l) || ((c == l + 1) && nen);
      e_en[p][c]   = (c >= l + 2) ? nen : 1'b0;
      if (c >= l + 1) begin
        e_sel[p][c] = nsel;
        e_cfg[p][c] = ncfg;
      end
      e_err[p][c] = to && (c >= l + 1);
    end
  endtask

  task automatic request(input int p, input logic nen, input logic [1:0] nsel,
                         input logic [63:0] ncfg, input int fpat);
    if (p == 0) begin
      slv_req_i      = 1'b1;
      slv_req_en_i   = nen;
      slv_req_mode_i = nsel;
      slv_req_cfg_i  = ncfg[SLV_CFG_W-1:0];
    end else begin
      mst_req_i      = 1'b1;
      mst_req_en_i   = nen;
      mst_req_dsp_i  = nsel[0];
      mst_req_cfg_i  = ncfg[MST_CFG_W-1:0];
    end
    if (!e_busy[p][cyc]) begin
      if (p == 0 && nsel == 2'd3) begin
        for (int c = cyc + 1; c < NC; c++) e_err[0][c] = 1'b1;
      end else begin
        schedule(p, cyc, nen, nsel, ncfg, fpat);
      end
    end
  endtask

  function automatic logic [63:0] rnd_cfg(input int w);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic check_all();
    check("s_en",    64'(cfg_slave_en_o),     64'(e_en[0][cyc]));
    check("s_pdm",   64'(cfg_slave_pdm_en_o), 64'(e_en[0][cyc] && e_sel[0][cyc] == 2'd1));
    check("s_dsp",   64'(cfg_slave_dsp_en_o), 64'(e_en[0][cyc] && e_sel[0][cyc] == 2'd2));
    check("s_cfg",   64'(cfg_slave_o),        e_cfg[0][cyc]);
    check("s_busy",  64'(slv_busy_o),         64'(e_busy[0][cyc]));
    check("s_err",   64'(slv_err_o),          64'(e_err[0][cyc]));
    check("m_en",    64'(cfg_master_en_o),    64'(e_en[1][cyc]));
    check("m_dsp",   64'(cfg_master_dsp_en_o), 64'(e_en[1][cyc] && e_sel[1][cyc][0]));
    check("m_cfg",   64'(cfg_master_o),       e_cfg[1][cyc]);
    check("m_busy",  64'(mst_busy_o),         64'(e_busy[1][cyc]));
    check("m_err",   64'(mst_err_o),          64'(e_err[1][cyc]));
  endtask

  initial begin
    slv_cfg_t    sc;
    logic [63:0] r;
    int          v;

    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NC; c++) begin
        e_en[p][c]   = 1'b0;
        e_sel[p][c]  = 2'd0;
        e_cfg[p][c]  = 64'd0;
        e_busy[p][c] = 1'b0;
        e_err[p][c]  = 1'b0;
        act[p][c]    = ($urandom_range(0, 7) == 0);
      end
    end

    rstn = 1'b0;
    slv_req_i = 1'b0; slv_req_en_i = 1'b0; slv_req_mode_i = 2'd0; slv_req_cfg_i = '0;
    mst_req_i = 1'b0; mst_req_en_i = 1'b0; mst_req_dsp_i = 1'b0; mst_req_cfg_i = '0;
    rx_valid_i = 1'b0; tx_valid_i = 1'b0; tx_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (cyc = 0; cyc < N; cyc++) begin
      @(posedge clk);
      #1;
      check_all();

      slv_req_i  = 1'b0;
      mst_req_i  = 1'b0;
      rx_valid_i = act[0][cyc];
      if (act[1][cyc]) begin
        tx_valid_i = 1'b1;
        tx_ready_i = 1'b1;
      end else begin
        v = $urandom_range(0, 2);
        tx_valid_i = (v == 2);
        tx_ready_i = (v == 1);
      end

      if (cyc == 0) begin
        r  = rnd_cfg(SLV_CFG_W);
        sc = r[SLV_CFG_W-1:0];
        sc.dsp_offset = 9'h1A;
        request(0, 1'b1, 2'd2, 64'(sc), -1);
      end else if (cyc == 300) begin
        request(0, 1'b0, 2'($urandom_range(0, 2)), rnd_cfg(SLV_CFG_W), -1);
        request(1, 1'b1, 2'd1, rnd_cfg(MST_CFG_W), -1);
      end else if (cyc < R_END) begin
        if ($urandom_range(0, 15) == 0)
          request(0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rnd_cfg(SLV_CFG_W), -1);
        if ($urandom_range(0, 15) == 0)
          request(1, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 1)), rnd_cfg(MST_CFG_W), -1);
      end else if (cyc == R_END + 1100) begin
        request(0, 1'b1, 2'd1, rnd_cfg(SLV_CFG_W), 1);
        request(1, 1'b1, 2'd1, rnd_cfg(MST_CFG_W), 1);
      end else if (cyc == R_END + 1200) begin
        request(0, 1'b1, 2'd2, rnd_cfg(SLV_CFG_W), 2);
        request(1, 1'b1, 2'd0, rnd_cfg(MST_CFG_W), 2);
      end
    end

    // Both paths are now mid-drain; reset must clear every output without a clock edge.
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_s_en",   64'(cfg_slave_en_o),      64'd0);
    check("rst_s_pdm",  64'(cfg_slave_pdm_en_o),  64'd0);
    check("rst_s_dsp",  64'(cfg_slave_dsp_en_o),  64'd0);
    check("rst_s_cfg",  64'(cfg_slave_o),         64'd0);
    check("rst_s_busy", 64'(slv_busy_o),          64'd0);
    check("rst_s_err",  64'(slv_err_o),           64'd0);
    check("rst_m_en",   64'(cfg_master_en_o),     64'd0);
    check("rst_m_dsp",  64'(cfg_master_dsp_en_o), 64'd0);
    check("rst_m_cfg",  64'(cfg_master_o),        64'd0);
    check("rst_m_busy", 64'(mst_busy_o),          64'd0);
    check("rst_m_err",  64'(mst_err_o),           64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_cfg_sequencer.md
# i2s_cfg_sequencer

- Sequences configuration changes for the I2S/PDM/DSP transceiver datapath, one sequencer for the slave (RX) path and one for the master (TX) path.
- Register-side requests are never applied to a running channel. The sequencer drops the channel enables, waits until the FIFO side has been quiet, loads the new configuration, then re-enables the channel.
- It sits between the register file and the transceiver's `cfg_*` inputs.
- It guarantees mutually exclusive I2S/PDM/DSP mode enables.

## Interface

Parameters:
- `QUIET_CYCLES`, default 16: consecutive idle cycles required before a new configuration is loaded.
- `DRAIN_TIMEOUT`, default 1024: maximum cycles spent draining before the load is forced.

Ports:
- `clk_i`, in, 1: single clock. All inputs are synchronous to it.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `slv_req_i`, in, 1: one-cycle apply strobe for the slave path.
- `slv_req_en_i`, in, 1: requested slave enable.
- `slv_req_mode_i`, in, 2: requested slave mode. 0 = I2S, 1 = PDM, 2 = DSP, 3 = reserved.
- `slv_req_cfg_i`, in, `SLV_CFG_W`: packed slave configuration bundle.
- `rx_valid_i`, in, 1: RX FIFO valid, used as the slave activity indicator.
- `cfg_slave_en_o`, `cfg_slave_pdm_en_o`, `cfg_slave_dsp_en_o`, out, 1 each: slave enables to the datapath.
- `cfg_slave_o`, out, `SLV_CFG_W`: applied slave configuration.
- `slv_busy_o`, out, 1: slave sequence in progress.
- `slv_err_o`, out, 1: sticky error flag (reserved mode or drain timeout).
- `mst_req_i`, `mst_req_en_i`, `mst_req_dsp_i`, in, 1 each: master apply strobe, requested enable, requested DSP mode.
- `mst_req_cfg_i`, in, `MST_CFG_W`: packed master configuration bundle.
- `tx_valid_i`, `tx_ready_i`, in, 1 each: TX FIFO handshake. Master activity = `tx_valid_i & tx_ready_i`.
- `cfg_master_en_o`, `cfg_master_dsp_en_o`, out, 1 each: master enables to the datapath.
- `cfg_master_o`, out, `MST_CFG_W`: applied master configuration.
- `mst_busy_o`, out, 1: master sequence in progress.
- `mst_err_o`, out, 1: sticky master drain-timeout flag.

## Operation

Each path has its own FSM with states IDLE, RUN, STOP, DRAIN, LOAD, START.
- **IDLE** (enables low): on a request, go to LOAD.
- **RUN** (enables high): on a request, go to STOP.
- **STOP**: drop all path enables. Unconditionally go to DRAIN.
- **DRAIN**: count consecutive cycles with activity low; activity high clears the counter.
  - Counter reaches `QUIET_CYCLES` → go to LOAD.
  - Total cycles in DRAIN reach `DRAIN_TIMEOUT` → set err and go to LOAD (forced load).
- **LOAD**: register the latched request into `cfg_*_o`.
  - Requested enable high → go to START.
  - Requested enable low → go to IDLE.
- **START**: drive the enables from the latched request, then go to RUN.

Request handling:
- A request is latched on the cycle `*_req_i` is high in IDLE or RUN.
- A request while busy is ignored: no latch, no error.
- Every request runs the full sequence, even if it matches the current configuration.

Slave mode decode:
- `cfg_slave_en_o` = en.
- `cfg_slave_pdm_en_o` = en & (mode == 1).
- `cfg_slave_dsp_en_o` = en & (mode == 2).
- Mode 3 is rejected: err is set, nothing is latched, the FSM does not leave its state.

Master mode decode:
- `cfg_master_en_o` = en.
- `cfg_master_dsp_en_o` = en & dsp.

Configuration bundles:
- `cfg_*_o` hold their old value through STOP and DRAIN.
- They change only in LOAD.

Busy and error:
- `*_busy_o` is high in every state except IDLE and RUN.
- `*_err_o` is cleared when a valid request is accepted, then re-set if that sequence times out.

Path independence:
- The two paths never interact.
- Simultaneous slave and master requests are both accepted.

## Timing

- Reset value of every output is 0; both FSMs reset to IDLE. Reset mid-sequence aborts it immediately, so enables drop asynchronously.
- **From IDLE:** request at cycle 0 → LOAD at 1 (`cfg_*_o` valid at 2) → START at 2 → enables high at 3 → RUN, busy low at 3.
- **From RUN:** request at cycle 0 → enables low from 1 (STOP) → DRAIN from 2.
  - With continuous quiet, LOAD is at 2+`QUIET_CYCLES`.
  - Enables return at 4+`QUIET_CYCLES`.
- **Counters:** both DRAIN counters clear on DRAIN entry. Widths are `$clog2` of the respective parameter plus 1.
- **Activity on the exact threshold cycle:** the counter clears and the load does not happen.
- **Timeout vs quiet threshold on the same cycle:** the quiet threshold wins, and err is not set.

## Structure

- Package `i2s_cfg_seq_pkg` holds:
  - the `slv_cfg_t` and `mst_cfg_t` packed structs and the `SLV_CFG_W` / `MST_CFG_W` constants;
  - the mode enum `I2S = 0, PDM = 1, DSP = 2`;
  - the FSM state enum.
- `slv_cfg_t` fields: `lsb_first`, `2ch`, `bits_word[4:0]`, `words[3:0]`, `pdm_mode[1:0]`, `pdm_decimation[9:0]`, `pdm_shift[2:0]`, `dsp_mode[1:0]`, `dsp_offset[8:0]`, `dsp_setup_time[15:0]`, `rx_continuous`.
- `mst_cfg_t` fields: `lsb_first`, `2ch`, `bits_word[4:0]`, `words[3:0]`, `dsp_mode[1:0]`, `dsp_offset[8:0]`, `dsp_setup_time[15:0]`.
- Sub-module `i2s_cfg_seq_fsm`:
  - generic FSM plus drain and timeout counters, parameterised by `CFG_W`;
  - inputs: req, en, cfg, activity;
  - outputs: en, cfg, busy, timeout;
  - instantiated once per path.
- Mode decode and reserved-mode rejection live in the top level.

## Test plan

1. **Enable from IDLE.** Reset, then a slave request with en = 1, mode = 2 and `dsp_offset` = 9'h1A at cycle 0 → `cfg_slave_o` valid at cycle 2; `cfg_slave_dsp_en_o` = 1 and `cfg_slave_pdm_en_o` = 0 at cycle 3; busy high for cycles 1–2.
2. **Reconfigure while running.** Slave in RUN, request mode = 1 with `rx_valid_i` low → enables low at cycle 1; LOAD at cycle 18 (`QUIET_CYCLES` = 16); `cfg_slave_pdm_en_o` high at cycle 20; `cfg_slave_dsp_en_o` never high.
3. **Activity restarts the drain count.** Same as scenario 2, but pulse `rx_valid_i` high at drain count 10 → LOAD delayed by 11 cycles.
4. **Drain timeout.** Hold `rx_valid_i` high during DRAIN → forced LOAD after 1024 DRAIN cycles; `slv_err_o` = 1; a next valid request clears it.
5. **Reserved mode and request while busy.** Slave request with mode = 3 → err set, outputs unchanged. A second request mid-DRAIN is ignored, and the final config equals the first request.
6. **Concurrent paths and reset mid-sequence.** Simultaneous master request (dsp = 1) and slave disable (en = 0) → master reaches RUN with `cfg_master_dsp_en_o` = 1; slave ends in IDLE with all enables 0. Asserting `rstn_i` low mid-DRAIN → all outputs 0 immediately.
